mem_bus_arbiter: RTL and testbench

Two-to-one arbiter that lets the pipeline's instruction-fetch port and load/store port share one memory bus. Both sides use the req/gnt/rvalid handshake. The block sits between the core's `instr_*`/`data_*` ports and a single-ported memory or interconnect. It chooses which requester drives each request, holds that choice stable until the memory grants it, and tracks outstanding transactions in order so each `rvalid` goes back to the requester that issued it.

---
 rtl/cpu_bus_pkg.sv | 15 +
 rtl/arb_id_fifo.sv | 73 +++++++
 rtl/mem_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared requester IDs and bus widths for the core-side memory arbiter.
// No logic: types and constants only.
// No flow control of its own.
package cpu_bus_pkg;

   localparam int BUS_ADDR_W = 32;
   localparam int BUS_DATA_W = 32;
   localparam int BUS_BE_W   = 4;

   typedef enum logic {
      REQ_INSTR = 1'b0,
      REQ_DATA  = 1'b1
   } req_id_e;

endpackage

// File: rtl/arb_id_fifo.sv
// Circular FIFO of requester IDs, one entry per granted but unanswered request.
// Latency: push visible at pop_id one cycle later; count/full/empty are registered.
// Backpressure: none internally; caller must not push when full or pop when empty.
module arb_id_fifo
   import cpu_bus_pkg::*;
#(
   parameter int  DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             push,
   input  req_id_e          push_id,
   input  logic             pop,
   output req_id_e          pop_id,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   req_id_e          mem_q [DEPTH];
   req_id_e          mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_id;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= REQ_INSTR;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign pop_id = mem_q[rd_ptr_q];
   assign count  = count_q;
   assign full   = (count_q == CNT_W'(DEPTH));
   assign empty  = (count_q == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-to-one fetch/load-store arbiter onto one req/gnt/rvalid memory bus; ARB_ROUND_ROBIN_EN selects round-robin over data priority.
// Latency: zero cycles on request, grant and response paths; only lock, ID FIFO and sticky flag are clocked.
// Backpressure: mem_req_o held low while MAX_OUTSTANDING responses are pending; a losing or stalled requester simply sees no gnt.
module mem_bus_arbiter
   import cpu_bus_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  instr_req_i,
   input  logic [BUS_ADDR_W-1:0] instr_addr_i,
   output logic                  instr_gnt_o,
   output logic                  instr_rvalid_o,
   output logic [BUS_DATA_W-1:0] instr_rdata_o,
   output logic                  instr_err_o,
   input  logic                  data_req_i,
   input  logic                  data_we_i,
   input  logic [BUS_BE_W-1:0]   data_be_i,
   input  logic [BUS_ADDR_W-1:0] data_addr_i,
   input  logic [BUS_DATA_W-1:0] data_wdata_i,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   output logic [BUS_DATA_W-1:0] data_rdata_o,
   output logic                  data_err_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [BUS_BE_W-1:0]   mem_be_o,
   output logic [BUS_ADDR_W-1:0] mem_addr_o,
   output logic [BUS_DATA_W-1:0] mem_wdata_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [BUS_DATA_W-1:0] mem_rdata_i,
   input  logic                  mem_err_i,
   output logic                  spurious_rsp_o
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic             lock_valid_q, lock_valid_d;
   req_id_e          lock_id_q, lock_id_d;
   logic             spurious_q, spurious_d;
   req_id_e          sel;
   logic             any_req;
   logic             push, pop;
   req_id_e          pop_id;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full, fifo_empty;
`ifdef ARB_ROUND_ROBIN_EN
   req_id_e          last_id_q, last_id_d;
`endif

   assign any_req = instr_req_i | data_req_i;

   always_comb begin
      sel = REQ_INSTR;
      if (lock_valid_q) begin
         sel = lock_id_q;
      end else if (instr_req_i && data_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
         sel = (last_id_q == REQ_DATA) ? REQ_INSTR : REQ_DATA;
`else
         sel = REQ_DATA;
`endif
      end else if (data_req_i) begin
         sel = REQ_DATA;
      end
   end

   always_comb begin
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (any_req) begin
         if (sel == REQ_DATA) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
         end else begin
            mem_be_o    = '1;
            mem_addr_o  = instr_addr_i;
         end
      end
   end

   assign mem_req_o   = any_req & ~fifo_full;
   assign push        = mem_req_o & mem_gnt_i;
   assign instr_gnt_o = push & (sel == REQ_INSTR);
   assign data_gnt_o  = push & (sel == REQ_DATA);

   // A response with nothing outstanding must not pop or reach either requester.
   assign pop            = mem_rvalid_i & ~fifo_empty;
   assign instr_rvalid_o = pop & (pop_id == REQ_INSTR);
   assign data_rvalid_o  = pop & (pop_id == REQ_DATA);
   assign instr_err_o    = instr_rvalid_o & mem_err_i;
   assign data_err_o     = data_rvalid_o & mem_err_i;
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;
   assign spurious_rsp_o = spurious_q;

   always_comb begin
      lock_valid_d = lock_valid_q;
      lock_id_d    = lock_id_q;
      if (mem_req_o) begin
         lock_valid_d = ~mem_gnt_i;
         lock_id_d    = mem_gnt_i ? lock_id_q : sel;
      end
      spurious_d = spurious_q | (mem_rvalid_i & (fifo_count == '0));
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      last_id_d = push ? sel : last_id_q;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         last_id_q <= REQ_INSTR;
      end else begin
         last_id_q <= last_id_d;
      end
   end
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         lock_valid_q <= 1'b0;
         lock_id_q    <= REQ_INSTR;
         spurious_q   <= 1'b0;
      end else begin
         lock_valid_q <= lock_valid_d;
         lock_id_q    <= lock_id_d;
         spurious_q   <= spurious_d;
      end
   end

   arb_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .push    (push),
      .push_id (sel),
      .pop     (pop),
      .pop_id  (pop_id),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with MAX_OUTSTANDING=2.
// Inputs change 1 ns after the rising edge; outputs are sampled 3 ns after it.
module tb_mem_bus_arbiter;

   logic        CLK;
   logic        RST_N;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
   logic [31:0] instr_rdata_o;
   logic        data_req_i, data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i, data_wdata_i;
   logic        data_gnt_o, data_rvalid_o, data_err_o;
   logic [31:0] data_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
   logic [31:0] mem_rdata_i;
   logic        spurious_rsp_o;

   int checks   = 0;
   int failures = 0;

   mem_bus_arbiter #(.MAX_OUTSTANDING(2)) dut (
      .CLK            (CLK),
      .RST_N          (RST_N),
      .instr_req_i    (instr_req_i),
      .instr_addr_i   (instr_addr_i),
      .instr_gnt_o    (instr_gnt_o),
      .instr_rvalid_o (instr_rvalid_o),
      .instr_rdata_o  (instr_rdata_o),
      .instr_err_o    (instr_err_o),
      .data_req_i     (data_req_i),
      .data_we_i      (data_we_i),
      .data_be_i      (data_be_i),
      .data_addr_i    (data_addr_i),
      .data_wdata_i   (data_wdata_i),
      .data_gnt_o     (data_gnt_o),
      .data_rvalid_o  (data_rvalid_o),
      .data_rdata_o   (data_rdata_o),
      .data_err_o     (data_err_o),
      .mem_req_o      (mem_req_o),
      .mem_we_o       (mem_we_o),
      .mem_be_o       (mem_be_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_gnt_i      (mem_gnt_i),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rdata_i    (mem_rdata_i),
      .mem_err_i      (mem_err_i),
      .spurious_rsp_o (spurious_rsp_o)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle_inputs();
      instr_req_i  = 1'b0;
      instr_addr_i = '0;
      data_req_i   = 1'b0;
      data_we_i    = 1'b0;
      data_be_i    = '0;
      data_addr_i  = '0;
      data_wdata_i = '0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      mem_err_i    = 1'b0;
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      idle_inputs();
      step();
      settle();
      checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%0h exp=0", mem_req_o); end
      checks++; if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== 69'd0) begin failures++; $display("FAIL rst_mem_fields got=%0h/%0h/%0h/%0h exp=0", mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o); end
      checks++; if ({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o} !== 6'd0) begin failures++; $display("FAIL rst_handshake got=%b exp=000000", {instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o}); end
      mem_rvalid_i = 1'b1;
      step();
      settle();
      checks++; if (spurious_rsp_o !== 1'b0) begin failures++; $display("FAIL rst_spurious_held got=%0h exp=0", spurious_rsp_o); end
      mem_rvalid_i = 1'b0;
      step();
      RST_N = 1'b1;
      step();
   endtask

   task automatic test_fetch();
      instr_req_i = 1'b1; instr_addr_i = 32'h100; mem_gnt_i = 1'b1;
      settle();
      checks++; if (instr_gnt_o !== 1'b1 || data_gnt_o !== 1'b0) begin failures++; $display("FAIL fetch_gnt got=%b%b exp=10", instr_gnt_o, data_gnt_o); end
      checks++; if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin failures++; $display("FAIL fetch_mux got=%0h/%0h/%0h/%0h exp=1/0/f/100", mem_req_o, mem_we_o, mem_be_o, mem_addr_o); end
      step();
      instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h13;
      settle();
      checks++; if (instr_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b0) begin failures++; $display("FAIL fetch_rvalid got=%b%b exp=10", instr_rvalid_o, data_rvalid_o); end
      checks++; if (instr_rdata_o !== 32'h13 || instr_err_o !== 1'b0) begin failures++; $display("FAIL fetch_rdata got=%0h err=%0h exp=13 err=0", instr_rdata_o, instr_err_o); end
      step();
      idle_inputs();
   endtask

   task automatic test_simultaneous();
      instr_req_i = 1'b1; instr_addr_i = 32'h104;
      data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF; data_addr_i = 32'h2000; data_wdata_i = 32'hDEADBEEF;
      mem_gnt_i = 1'b1;
      settle();
      checks++; if (data_gnt_o !== 1'b1 || instr_gnt_o !== 1'b0) begin failures++; $display("FAIL simul_first_gnt got=d%0h i%0h exp=d1 i0", data_gnt_o, instr_gnt_o); end
      checks++; if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 32'h2000, 32'hDEADBEEF}) begin failures++; $display("FAIL simul_store_mux got=%0h/%0h/%0h exp=1/2000/deadbeef", mem_we_o, mem_addr_o, mem_wdata_o); end
      step();
      data_req_i = 1'b0;
      settle();
      checks++; if (instr_gnt_o !== 1'b1 || {mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b0, 32'h104, 32'h0}) begin failures++; $display("FAIL simul_second_gnt got=%0h/%0h/%0h/%0h exp=1/0/104/0", instr_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o); end
      step();
      instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA0001;
      settle();
      checks++; if (data_rvalid_o !== 1'b1 || instr_rvalid_o !== 1'b0 || data_rdata_o !== 32'hAAAA0001) begin failures++; $display("FAIL simul_rsp1 got=d%0h i%0h %0h exp=d1 i0 aaaa0001", data_rvalid_o, instr_rvalid_o, data_rdata_o); end
      step();
      mem_rdata_i = 32'h55;
      settle();
      checks++; if (instr_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b0) begin failures++; $display("FAIL simul_rsp2 got=i%0h d%0h exp=i1 d0", instr_rvalid_o, data_rvalid_o); end
      step();
      idle_inputs();
   endtask

   task automatic test_lock();
      instr_req_i = 1'b1; instr_addr_i = 32'h104; mem_gnt_i = 1'b0;
      settle();
      checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h104 || instr_gnt_o !== 1'b0) begin failures++; $display("FAIL lock_c1 got=%0h/%0h/%0h exp=1/104/0", mem_req_o, mem_addr_o, instr_gnt_o); end
      step();
      data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'h3; data_addr_i = 32'h3000;
      for (int c = 2; c <= 3; c++) begin
         settle();
         checks++; if (mem_addr_o !== 32'h104 || mem_be_o !== 4'hF || data_gnt_o !== 1'b0) begin failures++; $display("FAIL lock_hold_c%0d got=%0h/%0h/%0h exp=104/f/0", c, mem_addr_o, mem_be_o, data_gnt_o); end
         step();
      end
      mem_gnt_i = 1'b1;
      settle();
      checks++; if (instr_gnt_o !== 1'b1 || data_gnt_o !== 1'b0 || mem_addr_o !== 32'h104) begin failures++; $display("FAIL lock_release got=i%0h d%0h %0h exp=i1 d0 104", instr_gnt_o, data_gnt_o, mem_addr_o); end
      step();
      instr_req_i = 1'b0;
      settle();
      checks++; if (data_gnt_o !== 1'b1 || mem_addr_o !== 32'h3000 || mem_be_o !== 4'h3) begin failures++; $display("FAIL lock_data_after got=%0h/%0h/%0h exp=1/3000/3", data_gnt_o, mem_addr_o, mem_be_o); end
      step();
      idle_inputs(); mem_rvalid_i = 1'b1;
      settle();
      checks++; if (instr_rvalid_o !== 1'b1) begin failures++; $display("FAIL lock_rsp_instr got=%0h exp=1", instr_rvalid_o); end
      step();
      settle();
      checks++; if (data_rvalid_o !== 1'b1) begin failures++; $display("FAIL lock_rsp_data got=%0h exp=1", data_rvalid_o); end
      step();
      idle_inputs();
   endtask

   task automatic test_full();
      instr_req_i = 1'b1; instr_addr_i = 32'h200; mem_gnt_i = 1'b1;
      settle();
      checks++; if (instr_gnt_o !== 1'b1) begin failures++; $display("FAIL full_gnt1 got=%0h exp=1", instr_gnt_o); end
      step();
      instr_addr_i = 32'h204;
      settle();
      checks++; if (instr_gnt_o !== 1'b1 || mem_req_o !== 1'b1) begin failures++; $display("FAIL full_gnt2 got=%0h/%0h exp=1/1", instr_gnt_o, mem_req_o); end
      step();
      instr_addr_i = 32'h208; mem_rvalid_i = 1'b1;
      settle();
      checks++; if (mem_req_o !== 1'b0 || instr_gnt_o !== 1'b0) begin failures++; $display("FAIL full_block got=%0h/%0h exp=0/0", mem_req_o, instr_gnt_o); end
      checks++; if (instr_rvalid_o !== 1'b1) begin failures++; $display("FAIL full_pop got=%0h exp=1", instr_rvalid_o); end
      step();
      mem_rvalid_i = 1'b0;
      settle();
      checks++; if (mem_req_o !== 1'b1 || instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h208) begin failures++; $display("FAIL full_unblock got=%0h/%0h/%0h exp=1/1/208", mem_req_o, instr_gnt_o, mem_addr_o); end
      step();
      idle_inputs(); mem_rvalid_i = 1'b1;
      step();
      step();
      idle_inputs();
   endtask

   task automatic test_err_spurious();
      data_req_i = 1'b1; data_be_i = 4'hF; data_addr_i = 32'h40; mem_gnt_i = 1'b1;
      settle();
      checks++; if (data_gnt_o !== 1'b1) begin failures++; $display("FAIL err_gnt got=%0h exp=1", data_gnt_o); end
      step();
      data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_err_i = 1'b1;
      settle();
      checks++; if ({data_rvalid_o, data_err_o, instr_rvalid_o, instr_err_o} !== 4'b1100) begin failures++; $display("FAIL err_route got=%b exp=1100", {data_rvalid_o, data_err_o, instr_rvalid_o, instr_err_o}); end
      step();
      mem_err_i = 1'b0;
      settle();
      checks++; if ({instr_rvalid_o, data_rvalid_o, spurious_rsp_o} !== 3'b000) begin failures++; $display("FAIL spur_drop got=%b exp=000", {instr_rvalid_o, data_rvalid_o, spurious_rsp_o}); end
      step();
      mem_rvalid_i = 1'b0;
      settle();
      checks++; if (spurious_rsp_o !== 1'b1) begin failures++; $display("FAIL spur_set got=%0h exp=1", spurious_rsp_o); end
      step(); step();
      settle();
      checks++; if (spurious_rsp_o !== 1'b1) begin failures++; $display("FAIL spur_sticky got=%0h exp=1", spurious_rsp_o); end
      RST_N = 1'b0;
      #1;
      checks++; if (spurious_rsp_o !== 1'b0) begin failures++; $display("FAIL spur_async_clear got=%0h exp=0", spurious_rsp_o); end
      step();
      RST_N = 1'b1;
      step();
   endtask

`ifdef ARB_ROUND_ROBIN_EN
   task automatic test_back_to_back();
      logic [3:0] exp_dgnt, exp_ignt, exp_drv, exp_irv;
      exp_dgnt = 4'b0101; exp_ignt = 4'b1010;
      exp_drv  = 4'b1010; exp_irv  = 4'b0100;
      instr_req_i = 1'b1; instr_addr_i = 32'h600;
      data_req_i = 1'b1; data_be_i = 4'hF; data_addr_i = 32'h700; mem_gnt_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         mem_rvalid_i = (c != 0);
         settle();
         checks++; if ({data_gnt_o, instr_gnt_o} !== {exp_dgnt[c], exp_ignt[c]}) begin failures++; $display("FAIL rr_gnt_c%0d got=d%0h i%0h exp=d%0h i%0h", c, data_gnt_o, instr_gnt_o, exp_dgnt[c], exp_ignt[c]); end
         checks++; if ({data_rvalid_o, instr_rvalid_o} !== {exp_drv[c], exp_irv[c]}) begin failures++; $display("FAIL rr_rsp_c%0d got=d%0h i%0h exp=d%0h i%0h", c, data_rvalid_o, instr_rvalid_o, exp_drv[c], exp_irv[c]); end
         step();
      end
      instr_req_i = 1'b0; data_req_i = 1'b0;
      settle();
      checks++; if (instr_rvalid_o !== 1'b1) begin failures++; $display("FAIL rr_last_rsp got=%0h exp=1", instr_rvalid_o); end
      step();
      idle_inputs();
   endtask
`else
   task automatic test_back_to_back();
      logic [31:0] addrs [3];
      addrs[0] = 32'h500; addrs[1] = 32'h504; addrs[2] = 32'h508;
      instr_req_i = 1'b1; instr_addr_i = 32'h600;
      data_req_i = 1'b1; data_be_i = 4'hF; mem_gnt_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         data_addr_i = addrs[c];
         mem_rvalid_i = (c != 0);
         settle();
         checks++; if (data_gnt_o !== 1'b1 || instr_gnt_o !== 1'b0 || mem_addr_o !== addrs[c]) begin failures++; $display("FAIL b2b_data_c%0d got=d%0h i%0h %0h exp=d1 i0 %0h", c, data_gnt_o, instr_gnt_o, mem_addr_o, addrs[c]); end
         checks++; if (data_rvalid_o !== (c != 0)) begin failures++; $display("FAIL b2b_rsp_c%0d got=%0h exp=%0h", c, data_rvalid_o, (c != 0)); end
         step();
      end
      data_req_i = 1'b0;
      settle();
      checks++; if (instr_gnt_o !== 1'b1 || data_rvalid_o !== 1'b1) begin failures++; $display("FAIL b2b_instr got=%0h/%0h exp=1/1", instr_gnt_o, data_rvalid_o); end
      step();
      instr_req_i = 1'b0;
      settle();
      checks++; if (instr_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b0) begin failures++; $display("FAIL b2b_last_rsp got=i%0h d%0h exp=i1 d0", instr_rvalid_o, data_rvalid_o); end
      step();
      idle_inputs();
      settle();
      checks++; if (spurious_rsp_o !== 1'b0) begin failures++; $display("FAIL b2b_no_spur got=%0h exp=0", spurious_rsp_o); end
   endtask
`endif

   initial begin
      test_reset();
      test_fetch();
      test_simultaneous();
      test_lock();
      test_full();
      test_err_spurious();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
